// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB pipeline stage with valid/ready handshake, flush and optional skid entry
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              reg_write_en_in,
    input  logic [ADDR_W-1:0] reg_addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              reg_write_en_out,
    output logic [ADDR_W-1:0] reg_addr_out,
    output logic              fwd_valid,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic consume;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [DATA_W-1:0] main_data;
    logic              main_we;
    logic [ADDR_W-1:0] main_addr;
    logic [DATA_W-1:0] skid_data;
    logic              skid_we;
    logic [ADDR_W-1:0] skid_addr;

    // Handshake qualifiers; a flushed input is never taken even if the upstream saw in_ready
    always_comb begin
        accept  = in_valid & in_ready & ~flush;
        consume = out_valid & out_ready;
    end

    // Next-state and register-load selection; flush overrides everything but reset
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_next   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        load_skid  = 1'b1;
                        state_next = ST_SKIDDED;
                    end else if (consume) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_SKIDDED: begin
                    if (consume) begin
                        load_main_skid = 1'b1;
                        state_next     = ST_FULL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Entry storage: main is the presented head, skid holds the entry that arrived during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_we   <= 1'b0;
            main_addr <= '0;
            skid_data <= '0;
            skid_we   <= 1'b0;
            skid_addr <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= data_in;
                main_we   <= reg_write_en_in;
                main_addr <= reg_addr_in;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_we   <= skid_we;
                main_addr <= skid_addr;
            end
            if (load_skid) begin
                skid_data <= data_in;
                skid_we   <= reg_write_en_in;
                skid_addr <= reg_addr_in;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Registered ready: cut the out_ready -> in_ready path; drop only while the skid is occupied
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_next != ST_SKIDDED);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = (state == ST_EMPTY) | out_ready;
        end
    endgenerate

    // Head outputs; write enable and forwarding are suppressed for bubbles
    always_comb begin
        out_valid        = (state != ST_EMPTY);
        data_out         = main_data;
        reg_addr_out     = main_addr;
        reg_write_en_out = out_valid & main_we;
        fwd_valid        = reg_write_en_out & (main_addr != '0);
    end

    // Occupancy count derived from the state
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ST_EMPTY:   occupancy = 2'd0;
            ST_FULL:    occupancy = 2'd1;
            ST_SKIDDED: occupancy = 2'd2;
            default:    occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - randomized and directed bench for mem_wb_pipe (SKID=1 and SKID=0 builds)
module tb_mem_wb_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef logic [DW+AW:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          reg_write_en_in = 1'b0;
    logic [AW-1:0] reg_addr_in = '0;
    logic          out_ready = 1'b0;

    logic          a_in_ready, a_out_valid, a_we, a_fwd;
    logic [DW-1:0] a_data;
    logic [AW-1:0] a_addr;
    logic [1:0]    a_occ;
    logic          b_in_ready, b_out_valid, b_we, b_fwd;
    logic [DW-1:0] b_data;
    logic [AW-1:0] b_addr;
    logic [1:0]    b_occ;

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .data_in(data_in), .reg_write_en_in(reg_write_en_in), .reg_addr_in(reg_addr_in),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .data_out(a_data), .reg_write_en_out(a_we), .reg_addr_out(a_addr),
        .fwd_valid(a_fwd), .occupancy(a_occ)
    );

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .data_in(data_in), .reg_write_en_in(reg_write_en_in), .reg_addr_in(reg_addr_in),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .data_out(b_data), .reg_write_en_out(b_we), .reg_addr_out(b_addr),
        .fwd_valid(b_fwd), .occupancy(b_occ)
    );

    int nchecks = 0;
    int nfail = 0;

    // Reference model: a FIFO of capacity 2 (q1, SKID=1) or 1 (q0, SKID=0) plus the last head shown
    ent_t q1[$];
    ent_t q0[$];
    ent_t last1 = '0;
    ent_t last0 = '0;

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic w, input logic [AW-1:0] a);
        in_valid = v;
        data_in = d;
        reg_write_en_in = w;
        reg_addr_in = a;
    endtask

    // Advance one clock edge and update the reference model from the inputs seen at that edge
    task automatic tick();
        logic acc1, acc0, con1, con0;
        ent_t e;
        @(posedge clk);
        e = {data_in, reg_write_en_in, reg_addr_in};
        if (rst) begin
            q1.delete();
            q0.delete();
            last1 = '0;
            last0 = '0;
        end else begin
            con1 = (q1.size() > 0) && out_ready;
            con0 = (q0.size() > 0) && out_ready;
            acc1 = in_valid && (q1.size() < 2) && !flush;
            acc0 = in_valid && ((q0.size() == 0) || out_ready) && !flush;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (con1) void'(q1.pop_front());
                if (acc1) q1.push_back(e);
                if (con0) void'(q0.pop_front());
                if (acc0) q0.push_back(e);
            end
            if (q1.size() > 0) last1 = q1[0];
            if (q0.size() > 0) last0 = q0[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd7);
        tick();
        tick();
        @(negedge clk);
        nchecks++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %0h want 0", a_out_valid); end
        nchecks++; if (a_we !== 1'b0) begin nfail++; $display("FAIL reset_we got %0h want 0", a_we); end
        nchecks++; if (a_data !== 32'h0) begin nfail++; $display("FAIL reset_data got %0h want 0", a_data); end
        nchecks++; if (a_addr !== 5'h0) begin nfail++; $display("FAIL reset_addr got %0h want 0", a_addr); end
        nchecks++; if (a_fwd !== 1'b0) begin nfail++; $display("FAIL reset_fwd got %0h want 0", a_fwd); end
        nchecks++; if (a_occ !== 2'd0) begin nfail++; $display("FAIL reset_occ got %0d want 0", a_occ); end
        nchecks++; if (a_in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %0h want 1", a_in_ready); end
        nchecks++; if (b_in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready_noskid got %0h want 1", b_in_ready); end
        nchecks++; if (b_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid_noskid got %0h want 0", b_out_valid); end
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        tick();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] sd [3];
        logic          sw [3];
        logic [AW-1:0] sa [3];
        logic          sf [3];
        sd = '{32'h11, 32'h22, 32'h33};
        sw = '{1'b1, 1'b1, 1'b0};
        sa = '{5'd3, 5'd4, 5'd5};
        sf = '{1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sd[i], sw[i], sa[i]);
            tick();
            nchecks++; if (a_out_valid !== 1'b1) begin nfail++; $display("FAIL stream_valid[%0d] got %0h want 1", i, a_out_valid); end
            nchecks++; if (a_data !== sd[i]) begin nfail++; $display("FAIL stream_data[%0d] got %0h want %0h", i, a_data, sd[i]); end
            nchecks++; if (a_we !== sw[i]) begin nfail++; $display("FAIL stream_we[%0d] got %0h want %0h", i, a_we, sw[i]); end
            nchecks++; if (a_addr !== sa[i]) begin nfail++; $display("FAIL stream_addr[%0d] got %0h want %0h", i, a_addr, sa[i]); end
            nchecks++; if (a_fwd !== sf[i]) begin nfail++; $display("FAIL stream_fwd[%0d] got %0h want %0h", i, a_fwd, sf[i]); end
            nchecks++; if (b_data !== sd[i]) begin nfail++; $display("FAIL stream_data_noskid[%0d] got %0h want %0h", i, b_data, sd[i]); end
        end
        drive(1'b0, '0, 1'b0, '0);
        tick();
        nchecks++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL stream_drain got %0h want 0", a_out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b1, 5'd6);
        tick();
        nchecks++; if (a_occ !== 2'd1) begin nfail++; $display("FAIL stall_occ1 got %0d want 1", a_occ); end
        drive(1'b1, 32'hB, 1'b1, 5'd7);
        @(negedge clk);
        nchecks++; if (b_in_ready !== 1'b0) begin nfail++; $display("FAIL stall_noskid_ready got %0h want 0", b_in_ready); end
        tick();
        nchecks++; if (a_occ !== 2'd2) begin nfail++; $display("FAIL stall_occ2 got %0d want 2", a_occ); end
        nchecks++; if (a_in_ready !== 1'b0) begin nfail++; $display("FAIL stall_in_ready got %0h want 0", a_in_ready); end
        nchecks++; if (a_data !== 32'hA) begin nfail++; $display("FAIL stall_head_a got %0h want a", a_data); end
        drive(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        tick();
        nchecks++; if (a_data !== 32'hB || a_out_valid !== 1'b1) begin nfail++; $display("FAIL stall_head_b got %0h/%0h want b/1", a_data, a_out_valid); end
        nchecks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin nfail++; $display("FAIL stall_after_occ got %0d/%0h want 1/1", a_occ, a_in_ready); end
        tick();
        nchecks++; if (a_out_valid !== 1'b0 || a_we !== 1'b0) begin nfail++; $display("FAIL stall_empty got %0h/%0h want 0/0", a_out_valid, a_we); end
        nchecks++; if (a_data !== 32'hB) begin nfail++; $display("FAIL stall_hold got %0h want b", a_data); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b1, 5'd1);
        tick();
        drive(1'b1, 32'hB, 1'b1, 5'd2);
        tick();
        nchecks++; if (a_occ !== 2'd2) begin nfail++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
        flush = 1'b1;
        drive(1'b1, 32'hC, 1'b1, 5'd9);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        nchecks++; if (a_out_valid !== 1'b0 || a_we !== 1'b0) begin nfail++; $display("FAIL flush_valid got %0h/%0h want 0/0", a_out_valid, a_we); end
        nchecks++; if (a_occ !== 2'd0) begin nfail++; $display("FAIL flush_occ got %0d want 0", a_occ); end
        nchecks++; if (a_in_ready !== 1'b1) begin nfail++; $display("FAIL flush_in_ready got %0h want 1", a_in_ready); end
        out_ready = 1'b1;
        tick();
        tick();
        nchecks++; if (a_out_valid !== 1'b0 || a_data !== 32'hA) begin nfail++; $display("FAIL flush_no_c got %0h/%0h want 0/a", a_out_valid, a_data); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b1, 5'd2);
        tick();
        nchecks++; if (a_occ !== 2'd1) begin nfail++; $display("FAIL rstmid_occ got %0d want 1", a_occ); end
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h99, 1'b1, 5'd4);
        tick();
        nchecks++; if ({a_out_valid, a_we, a_fwd, a_occ} !== 5'b0 || a_data !== 32'h0 || a_addr !== 5'h0) begin nfail++; $display("FAIL rstmid_zero got v%0h we%0h d%0h a%0h occ%0d want all 0", a_out_valid, a_we, a_data, a_addr, a_occ); end
        nchecks++; if (a_in_ready !== 1'b1) begin nfail++; $display("FAIL rstmid_in_ready got %0h want 1", a_in_ready); end
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hD0, 1'b1, 5'd8);
        tick();
        nchecks++; if (a_out_valid !== 1'b1 || a_data !== 32'hD0 || a_fwd !== 1'b1) begin nfail++; $display("FAIL rstmid_first got %0h/%0h/%0h want 1/d0/1", a_out_valid, a_data, a_fwd); end
        drive(1'b0, '0, 1'b0, '0);
        tick();
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 1'b1, 5'd0);
        tick();
        nchecks++; if (a_fwd !== 1'b0 || a_we !== 1'b1) begin nfail++; $display("FAIL zreg_fwd_we got %0h/%0h want 0/1", a_fwd, a_we); end
        drive(1'b0, '0, 1'b0, '0);
        tick();
        nchecks++; if (a_out_valid !== 1'b0 || a_we !== 1'b0) begin nfail++; $display("FAIL zreg_bubble got %0h/%0h want 0/0", a_out_valid, a_we); end
        nchecks++; if (a_data !== 32'h55 || b_data !== 32'h55) begin nfail++; $display("FAIL zreg_hold got %0h/%0h want 55/55", a_data, b_data); end
    endtask

    task automatic test_noskid();
        out_ready = 1'b0;
        drive(1'b1, 32'h61, 1'b1, 5'd1);
        tick();
        drive(1'b1, 32'h62, 1'b1, 5'd2);
        @(negedge clk);
        nchecks++; if (b_in_ready !== 1'b0) begin nfail++; $display("FAIL noskid_stall_ready got %0h want 0", b_in_ready); end
        out_ready = 1'b1;
        #1;
        nchecks++; if (b_in_ready !== 1'b1) begin nfail++; $display("FAIL noskid_comb_ready got %0h want 1", b_in_ready); end
        tick();
        nchecks++; if (b_out_valid !== 1'b1 || b_data !== 32'h62 || b_occ !== 2'd1) begin nfail++; $display("FAIL noskid_replace got %0h/%0h/%0d want 1/62/1", b_out_valid, b_data, b_occ); end
        drive(1'b0, '0, 1'b0, '0);
        tick();
        tick();
    endtask

    task automatic test_random();
        ent_t h1, h0;
        logic v1, v0, w1, w0, r0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            @(negedge clk);
            h1 = (q1.size() > 0) ? q1[0] : last1;
            h0 = (q0.size() > 0) ? q0[0] : last0;
            v1 = (q1.size() > 0);
            v0 = (q0.size() > 0);
            w1 = v1 & h1[AW];
            w0 = v0 & h0[AW];
            r0 = (q0.size() == 0) || out_ready;
            nchecks++; if (a_out_valid !== v1 || a_we !== w1 || a_fwd !== (w1 && h1[AW-1:0] != 0)) begin nfail++; $display("FAIL rnd_ctl cyc%0d got v%0h we%0h f%0h want v%0h we%0h", n, a_out_valid, a_we, a_fwd, v1, w1); end
            nchecks++; if (a_data !== h1[DW+AW:AW+1] || a_addr !== h1[AW-1:0]) begin nfail++; $display("FAIL rnd_data cyc%0d got %0h/%0h want %0h/%0h", n, a_data, a_addr, h1[DW+AW:AW+1], h1[AW-1:0]); end
            nchecks++; if (a_occ !== 2'(q1.size()) || a_in_ready !== (q1.size() < 2)) begin nfail++; $display("FAIL rnd_occ cyc%0d got %0d/%0h want %0d", n, a_occ, a_in_ready, q1.size()); end
            nchecks++; if (b_out_valid !== v0 || b_we !== w0 || b_fwd !== (w0 && h0[AW-1:0] != 0)) begin nfail++; $display("FAIL rnd_ctl_noskid cyc%0d got v%0h we%0h f%0h want v%0h we%0h", n, b_out_valid, b_we, b_fwd, v0, w0); end
            nchecks++; if (b_data !== h0[DW+AW:AW+1] || b_addr !== h0[AW-1:0]) begin nfail++; $display("FAIL rnd_data_noskid cyc%0d got %0h/%0h want %0h/%0h", n, b_data, b_addr, h0[DW+AW:AW+1], h0[AW-1:0]); end
            nchecks++; if (b_occ !== 2'(q0.size()) || b_in_ready !== r0) begin nfail++; $display("FAIL rnd_occ_noskid cyc%0d got %0d/%0h want %0d/%0h", n, b_occ, b_in_ready, q0.size(), r0); end
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_reset_mid();
        test_zero_reg();
        test_noskid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a synchronous flush, and an optional two-entry skid buffer. It carries the writeback value, its register-write enable and its destination register from the memory stage to the register file. It also exports a forwarding tag for hazard logic. Unlike a plain flop stage, it can absorb a downstream stall without combinational ready paths, and it never presents a register write for a bubble.

## Interface
- `DATA_W`, 32, width of writeback data
- `ADDR_W`, 5, width of destination register address
- `SKID`, 1; 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all held and incoming entries
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  stage accepts the entry this cycle
- `data_in`  in  DATA_W  writeback value
- `reg_write_en_in`  in  1  entry writes the register file
- `reg_addr_in`  in  ADDR_W  destination register
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream consumes the head this cycle
- `data_out`  out  DATA_W  head writeback value
- `reg_write_en_out`  out  1  head write enable, gated by `out_valid`
- `reg_addr_out`  out  ADDR_W  head destination register
- `fwd_valid`  out  1  equals `out_valid & reg_write_en_out & (reg_addr_out != 0)`
- `occupancy`  out  2  number of held entries (0..2; never exceeds 1 when `SKID`=0)

## Operation
- Accept: `in_valid & in_ready` at a rising edge. Consume: `out_valid & out_ready` at a rising edge.
- Storage: a main register (head) and, when `SKID`=1, a skid register. Each entry holds {data, we, addr}.
- States: EMPTY (occ 0), FULL (occ 1), SKIDDED (occ 2; exists only when `SKID`=1).
- EMPTY:
  - accept: load main, go to FULL.
  - otherwise: stay in EMPTY.
- FULL:
  - accept & consume: load main from input, stay in FULL.
  - accept & no consume: load skid from input, go to SKIDDED.
  - consume & no accept: go to EMPTY.
  - neither: hold.
- SKIDDED:
  - consume: main <= skid, go to FULL.
  - no consume: hold.
  - `in_ready`=0, so no accept is possible.
- `in_ready`:
  - `SKID`=1: registered; equals (next state != SKIDDED).
  - `SKID`=0: combinational; equals (state==EMPTY) | `out_ready`.
- `out_valid` = (state != EMPTY), driven from registers only.
- Write-enable gating: `reg_write_en_out` = 0 whenever `out_valid`=0. `data_out` and `reg_addr_out` hold their last loaded value while EMPTY.
- Flush:
  - next state is EMPTY and the skid register is invalidated.
  - any same-cycle accept is discarded.
  - `in_ready` (`SKID`=1) returns to 1 on the following cycle.
  - flush overrides consume, but the downstream handshake on that edge still completes. The head presented on that cycle counts as consumed; it is not replayed.
- Reset: same as flush, plus all data registers cleared. Reset has priority over flush.
- Ordering: strict FIFO. A skid entry is never presented before the main entry.

## Timing
- Latency: 1 cycle. An input accepted at edge N is visible on the outputs after edge N, provided it lands in main.
- Throughput: 1 entry per cycle while `out_ready`=1.
- `SKID`=1: no combinational path from `out_ready` to `in_ready`. `SKID`=0: there is one such path.
- Outputs with `rst` high at an edge, after that edge:
  - `out_valid`=0, `reg_write_en_out`=0, `data_out`=0, `reg_addr_out`=0, `fwd_valid`=0, `occupancy`=0.
  - `in_ready`=1 (`SKID`=1), or `in_ready`=1 via the EMPTY term (`SKID`=0).
- Inputs are ignored on any edge where `rst` is high.
- Stall of 1 cycle in FULL with `in_valid`=1 (`SKID`=1):
  - the stalled input goes to skid and `occupancy` goes to 2.
  - `in_ready` drops the next cycle.
  - when `out_ready` returns, the skid entry is presented one cycle after the main entry is consumed.

## Test plan
- Streaming: `SKID`=1, `out_ready`=1, inputs (0x11,we1,r3), (0x22,we1,r4), (0x33,we0,r5) on consecutive cycles -> same three entries appear on the outputs one cycle later, back to back; `fwd_valid`=1,1,0.
- Stall absorb: in FULL holding 0xA, `out_ready`=0 while 0xB is accepted -> `occupancy`=2 and `in_ready`=0 next cycle. After `out_ready` rises: 0xA, then 0xB on the next cycle, no loss or duplicate.
- Flush mid-stream: SKIDDED holding 0xA/0xB, assert `flush` with `in_valid`=1 carrying 0xC -> next cycle `out_valid`=0, `reg_write_en_out`=0, `occupancy`=0, `in_ready`=1; 0xC never appears.
- Reset mid-operation: assert `rst` in FULL with `flush` also high -> all outputs zero next cycle. Deassert: the first accepted entry appears after 1 cycle.
- Zero-register and bubble: entry (0x55,we1,r0) -> `fwd_valid`=0 and `reg_write_en_out`=1. When EMPTY after it drains, `reg_write_en_out`=0 and `data_out` holds 0x55.
- `SKID`=0 build: in FULL with `out_ready`=0 -> `in_ready`=0 in the same cycle. With `out_ready`=1 -> `in_ready`=1 and main is replaced with no bubble.
